// File: rtl/m6809_uart_if.sv
// m6809_uart_if: core-side byte bus of the UART responder.
//   sel   - chip-select from the address decode
//   wr_n  - 0 = write, 1 = read
//   a     - register address
//   din   - write data from the core
//   dout  - read data to the core (combinational)
//   irq   - level interrupt request, active-high
interface m6809_uart_if;
    logic       sel;
    logic       wr_n;
    logic [1:0] a;
    logic [7:0] din;
    logic [7:0] dout;
    logic       irq;

    modport master (output sel, wr_n, a, din, input dout, irq);
    modport slave  (input sel, wr_n, a, din, output dout, irq);
endinterface

// File: rtl/m6809_uart.sv
// m6809_uart: memory-mapped UART on the m6809 internal byte bus.
//   clk, reset - system clock, synchronous active-high reset
//   bus        - slave side of m6809_uart_if (register access, irq)
//   txd        - serial transmit, idle high
//   rxd        - serial receive, asynchronous, idle high
// Registers: 0 STATUS(r)/CONTROL(w), 1 RXDATA(r)/TXHOLD(w), 2 DIV[7:0], 3 DIV[15:8].
module m6809_uart #(
    parameter logic [15:0] DIV_RESET = 16'd434
) (
    input  logic        clk,
    input  logic        reset,
    m6809_uart_if.slave bus,
    output logic        txd,
    input  logic        rxd
);

    typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_t;

    logic [15:0] div_q, div_d;
    logic        rie_q, rie_d, tie_q, tie_d;
    logic        tdre_q, tdre_d, rdrf_q, rdrf_d, oe_q, oe_d, fe_q, fe_d;
    logic [7:0]  rxdata_q, rxdata_d, txhold_q, txhold_d;
    logic        irq_q, irq_d;

    state_t      tx_state_q, tx_state_d;
    logic [15:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]  tx_bit_q, tx_bit_d;
    logic [7:0]  tx_shift_q, tx_shift_d;
    logic        txd_q, txd_d;

    logic        rx_s1_q, rx_s1_d, rx_s2_q, rx_s2_d, rx_prev_q, rx_prev_d;
    state_t      rx_state_q, rx_state_d;
    logic [15:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]  rx_bit_q, rx_bit_d;
    logic [7:0]  rx_shift_q, rx_shift_d;

    logic        wr_en, rd_en, tx_load;
    logic [15:0] div_eff;

    assign txd     = txd_q;
    assign bus.irq = irq_q;

    always_comb begin
        bus.dout = 8'h00;
        if (bus.sel && bus.wr_n) begin
            case (bus.a)
                2'd0:    bus.dout = {4'b0, fe_q, oe_q, tdre_q, rdrf_q};
                2'd1:    bus.dout = rxdata_q;
                2'd2:    bus.dout = div_q[7:0];
                default: bus.dout = div_q[15:8];
            endcase
        end
    end

    always_comb begin
        wr_en   = bus.sel & ~bus.wr_n;
        rd_en   = bus.sel & bus.wr_n;
        div_eff = (div_q < 16'd2) ? 16'd2 : div_q;
        tx_load = 1'b0;

        div_d      = div_q;
        rie_d      = rie_q;
        tie_d      = tie_q;
        tdre_d     = tdre_q;
        rdrf_d     = rdrf_q;
        oe_d       = oe_q;
        fe_d       = fe_q;
        rxdata_d   = rxdata_q;
        txhold_d   = txhold_q;
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_s1_d    = rxd;
        rx_s2_d    = rx_s1_q;
        rx_prev_d  = rx_s2_q;

        if (wr_en) begin
            case (bus.a)
                2'd0: begin
                    rie_d = bus.din[0];
                    tie_d = bus.din[1];
                end
                2'd1: begin
                    // A write while the holding register is full is dropped.
                    if (tdre_q) begin
                        txhold_d = bus.din;
                        tdre_d   = 1'b0;
                    end
                end
                2'd2:    div_d[7:0]  = bus.din;
                default: div_d[15:8] = bus.din;
            endcase
        end

        if (rd_en && bus.a == 2'd1) begin
            rdrf_d = 1'b0;
            oe_d   = 1'b0;
            fe_d   = 1'b0;
        end

        case (tx_state_q)
            ST_IDLE: tx_load = ~tdre_q;
            ST_START: begin
                if (tx_cnt_q == 16'd0) begin
                    tx_state_d = ST_DATA;
                    tx_cnt_d   = div_eff - 16'd1;
                    tx_bit_d   = 3'd0;
                end else begin
                    tx_cnt_d = tx_cnt_q - 16'd1;
                end
            end
            ST_DATA: begin
                if (tx_cnt_q == 16'd0) begin
                    tx_shift_d = {1'b0, tx_shift_q[7:1]};
                    tx_cnt_d   = div_eff - 16'd1;
                    tx_bit_d   = tx_bit_q + 3'd1;
                    if (tx_bit_q == 3'd7) tx_state_d = ST_STOP;
                end else begin
                    tx_cnt_d = tx_cnt_q - 16'd1;
                end
            end
            default: begin
                if (tx_cnt_q == 16'd0) begin
                    // Chain straight into the next frame when a byte is waiting.
                    if (!tdre_q) tx_load = 1'b1;
                    else         tx_state_d = ST_IDLE;
                end else begin
                    tx_cnt_d = tx_cnt_q - 16'd1;
                end
            end
        endcase

        if (tx_load) begin
            tx_shift_d = txhold_q;
            tdre_d     = 1'b1;
            tx_state_d = ST_START;
            tx_cnt_d   = div_eff - 16'd1;
        end

        case (tx_state_d)
            ST_START: txd_d = 1'b0;
            ST_DATA:  txd_d = tx_shift_d[0];
            default:  txd_d = 1'b1;
        endcase

        case (rx_state_q)
            ST_IDLE: begin
                if (!rx_s2_q && rx_prev_q) begin
                    rx_state_d = ST_START;
                    rx_cnt_d   = (div_eff >> 1) - 16'd1;
                end
            end
            ST_START: begin
                if (rx_cnt_q == 16'd0) begin
                    if (!rx_s2_q) begin
                        rx_state_d = ST_DATA;
                        rx_cnt_d   = div_eff - 16'd1;
                        rx_bit_d   = 3'd0;
                    end else begin
                        rx_state_d = ST_IDLE;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q - 16'd1;
                end
            end
            ST_DATA: begin
                if (rx_cnt_q == 16'd0) begin
                    rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
                    rx_cnt_d   = div_eff - 16'd1;
                    rx_bit_d   = rx_bit_q + 3'd1;
                    if (rx_bit_q == 3'd7) rx_state_d = ST_STOP;
                end else begin
                    rx_cnt_d = rx_cnt_q - 16'd1;
                end
            end
            default: begin
                if (rx_cnt_q == 16'd0) begin
                    rx_state_d = ST_IDLE;
                    // rdrf_d already reflects a same-edge RXDATA read.
                    if (!rdrf_d) begin
                        rxdata_d = rx_shift_q;
                        rdrf_d   = 1'b1;
                        fe_d     = ~rx_s2_q;
                    end else begin
                        oe_d = 1'b1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q - 16'd1;
                end
            end
        endcase

        irq_d = (rie_q & rdrf_q) | (tie_q & tdre_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_q      <= DIV_RESET;
            rie_q      <= 1'b0;
            tie_q      <= 1'b0;
            tdre_q     <= 1'b1;
            rdrf_q     <= 1'b0;
            oe_q       <= 1'b0;
            fe_q       <= 1'b0;
            rxdata_q   <= 8'h00;
            txhold_q   <= 8'h00;
            irq_q      <= 1'b0;
            tx_state_q <= ST_IDLE;
            tx_cnt_q   <= 16'd0;
            tx_bit_q   <= 3'd0;
            tx_shift_q <= 8'h00;
            txd_q      <= 1'b1;
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= ST_IDLE;
            rx_cnt_q   <= 16'd0;
            rx_bit_q   <= 3'd0;
            rx_shift_q <= 8'h00;
        end else begin
            div_q      <= div_d;
            rie_q      <= rie_d;
            tie_q      <= tie_d;
            tdre_q     <= tdre_d;
            rdrf_q     <= rdrf_d;
            oe_q       <= oe_d;
            fe_q       <= fe_d;
            rxdata_q   <= rxdata_d;
            txhold_q   <= txhold_d;
            irq_q      <= irq_d;
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            txd_q      <= txd_d;
            rx_s1_q    <= rx_s1_d;
            rx_s2_q    <= rx_s2_d;
            rx_prev_q  <= rx_prev_d;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
        end
    end

endmodule

// File: tb/tb_m6809_uart.sv
// tb_m6809_uart: directed + randomized bench for m6809_uart with a
// frame-level reference model of the receive flags and transmit line.
module tb_m6809_uart;

    logic clk = 1'b0;
    logic reset;
    logic txd;
    logic rxd;

    m6809_uart_if bus();

    m6809_uart #(.DIV_RESET(16'd434)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .txd   (txd),
        .rxd   (rxd)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // receive-side model, frame granularity
    logic       rdrf_m, oe_m, fe_m;
    logic [7:0] rxdata_m;

    function automatic logic [7:0] status_m();
        return {4'b0, fe_m, oe_m, 1'b1, rdrf_m};
    endfunction

    task automatic model_reset();
        rdrf_m = 1'b0; oe_m = 1'b0; fe_m = 1'b0; rxdata_m = 8'h00;
    endtask

    task automatic model_clear();
        rdrf_m = 1'b0; oe_m = 1'b0; fe_m = 1'b0;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // All bus tasks are entered at a falling edge and return at a falling edge.
    task automatic bus_write(input logic [1:0] addr, input logic [7:0] data);
        bus.sel = 1'b1; bus.wr_n = 1'b0; bus.a = addr; bus.din = data;
        @(negedge clk);
        bus.sel = 1'b0; bus.wr_n = 1'b1;
    endtask

    task automatic bus_read(input logic [1:0] addr, output logic [7:0] data);
        bus.sel = 1'b1; bus.wr_n = 1'b1; bus.a = addr;
        #1 data = bus.dout;
        @(negedge clk);
        bus.sel = 1'b0;
    endtask

    task automatic read_check(input logic [1:0] addr, input logic [7:0] exp, input string tag);
        logic [7:0] d;
        bus_read(addr, d);
        check(tag, {8'h00, d}, {8'h00, exp});
    endtask

    task automatic set_div(input logic [15:0] d);
        bus_write(2'd2, d[7:0]);
        bus_write(2'd3, d[15:8]);
    endtask

    // Expects the frame to start at the next falling edge after the call.
    task automatic tx_expect(input logic [7:0] b, input int d, input logic chk_tdre, input string tag);
        logic [9:0] f;
        f = {1'b1, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            for (int j = 0; j < d; j++) begin
                @(negedge clk);
                if (chk_tdre && i == 0 && j == 0)
                    check("tdre_after_write", {15'd0, bus.dout[1]}, 16'd1);
                check(tag, {15'd0, txd}, {15'd0, f[i]});
            end
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop, input int d);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rxd = f[i];
            repeat (d) @(negedge clk);
        end
        rxd = 1'b1;
        if (!rdrf_m) begin
            rxdata_m = b; rdrf_m = 1'b1; fe_m = ~stop;
        end else begin
            oe_m = 1'b1;
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic mon_rdrf(input int limit, output int k, output logic irq_at, output logic irq_next);
        k = -1; irq_at = 1'bx; irq_next = 1'bx;
        bus.sel = 1'b1; bus.wr_n = 1'b1; bus.a = 2'd0;
        for (int c = 1; c <= limit; c++) begin
            @(negedge clk);
            if (bus.dout[0] === 1'b1) begin
                k = c; irq_at = bus.irq;
                break;
            end
        end
        if (k > 0) begin
            @(negedge clk);
            irq_next = bus.irq;
        end
        bus.sel = 1'b0;
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b, b1, b2;
        int         k, raw, deff, d;
        logic       ia, inx, stp;

        reset = 1'b1; rxd = 1'b1;
        bus.sel = 1'b0; bus.wr_n = 1'b1; bus.a = 2'd0; bus.din = 8'h00;
        model_reset();
        repeat (3) begin
            @(negedge clk);
            check("txd_in_reset", {15'd0, txd}, 16'd1);
            check("irq_in_reset", {15'd0, bus.irq}, 16'd0);
        end
        reset = 1'b0;
        @(negedge clk);
        check("txd_after_reset", {15'd0, txd}, 16'd1);
        check("irq_after_reset", {15'd0, bus.irq}, 16'd0);
        read_check(2'd0, 8'h02, "reset_status");
        read_check(2'd2, 8'hB2, "reset_div_lo");
        read_check(2'd3, 8'h01, "reset_div_hi");
        read_check(2'd1, 8'h00, "reset_rxdata");

        // single byte, DIV=4
        set_div(16'd4);
        bus_write(2'd1, 8'hA5);
        bus.sel = 1'b1; bus.wr_n = 1'b1; bus.a = 2'd0;
        tx_expect(8'hA5, 4, 1'b1, "tx_a5");
        bus.sel = 1'b0;

        // back-to-back frames; third write lands while TDRE=0
        bus_write(2'd1, 8'h55);
        fork
            begin
                tx_expect(8'h55, 4, 1'b0, "b2b_first");
                tx_expect(8'h0F, 4, 1'b0, "b2b_second");
            end
            begin
                @(negedge clk);
                bus_write(2'd1, 8'h0F);
                bus_write(2'd1, 8'h77);
            end
        join
        repeat (8) begin
            @(negedge clk);
            check("b2b_discard_idle", {15'd0, txd}, 16'd1);
        end
        read_check(2'd0, 8'h02, "b2b_status");

        // random divisors including 0/1 (treated as 2)
        for (int n = 0; n < 4; n++) begin
            raw  = $urandom_range(0, 5);
            deff = (raw < 2) ? 2 : raw;
            b    = 8'($urandom);
            set_div(16'(raw));
            read_check(2'd2, 8'(raw), "tx_rand_div_rd");
            bus_write(2'd1, b);
            tx_expect(b, deff, 1'b0, "tx_rand");
        end

        // receive 0x3C at DIV=8 with latency window
        set_div(16'd8);
        fork
            send_frame(8'h3C, 1'b1, 8);
            mon_rdrf(200, k, ia, inx);
        join
        check("rx_latency_window", {15'd0, (k >= 77 && k <= 79)}, 16'd1);
        check("rx_irq_disabled", {14'd0, ia, inx}, 16'd0);
        read_check(2'd0, status_m(), "rx_3c_status");
        read_check(2'd1, rxdata_m, "rx_3c_data");
        model_clear();
        read_check(2'd0, status_m(), "rx_3c_status_clr");

        // framing error then overrun
        b1 = 8'($urandom);
        b2 = 8'($urandom);
        send_frame(b1, 1'b0, 8);
        read_check(2'd0, status_m(), "rx_fe_status");
        send_frame(b2, 1'b1, 8);
        read_check(2'd0, status_m(), "rx_oe_status");
        read_check(2'd1, rxdata_m, "rx_oe_keeps_first");
        model_clear();
        read_check(2'd0, status_m(), "rx_oe_cleared");

        // glitch rejection and receive interrupt
        bus_write(2'd0, 8'h01);
        rxd = 1'b0;
        @(negedge clk);
        rxd = 1'b1;
        repeat (20) begin
            @(negedge clk);
            check("glitch_irq_low", {15'd0, bus.irq}, 16'd0);
        end
        read_check(2'd0, status_m(), "glitch_status");
        b = 8'($urandom);
        fork
            send_frame(b, 1'b1, 8);
            mon_rdrf(200, k, ia, inx);
        join
        check("irq_seen_rdrf", {15'd0, (k > 0)}, 16'd1);
        check("irq_lag", {14'd0, ia, inx}, 16'd1);
        read_check(2'd1, rxdata_m, "irq_frame_data");
        model_clear();
        bus_write(2'd0, 8'h00);

        // random receive traffic against the flag model
        d = $urandom_range(6, 12);
        set_div(16'(d));
        for (int n = 0; n < 6; n++) begin
            b   = 8'($urandom);
            stp = ($urandom_range(0, 3) != 0);
            send_frame(b, stp, d);
            read_check(2'd0, status_m(), "rx_rand_status");
            if ($urandom_range(0, 1) == 1) begin
                read_check(2'd1, rxdata_m, "rx_rand_data");
                model_clear();
            end
        end
        read_check(2'd1, rxdata_m, "rx_rand_final_data");
        model_clear();

        // reset mid-transmit
        bus_write(2'd0, 8'h03);
        set_div(16'd4);
        bus_write(2'd1, 8'hC3);
        repeat (3) @(negedge clk);
        check("tx_midframe_low", {15'd0, txd}, 16'd0);
        reset = 1'b1;
        @(negedge clk);
        check("reset_midframe_txd", {15'd0, txd}, 16'd1);
        check("reset_midframe_irq", {15'd0, bus.irq}, 16'd0);
        reset = 1'b0;
        model_reset();
        read_check(2'd0, 8'h02, "reset_midframe_status");
        read_check(2'd2, 8'hB2, "reset_midframe_div");
        repeat (10) begin
            @(negedge clk);
            check("reset_midframe_idle", {15'd0, txd}, 16'd1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/m6809_uart.md
# m6809_uart

Memory-mapped UART responder on the m6809 core's internal byte bus. It answers core reads and writes to four registers and serialises transmit bytes onto `txd`. It deserialises `rxd` into a receive holding register and raises `irq` on enabled events. It sits beside RAM/ROM in the address decode, selected by a chip-select from the integration layer, and its `dout` feeds the core data-in mux.

## Interface
- `DIV_RESET`, 16'd434: reset value of the baud divisor, in clocks per bit.
- `clk` in 1: system clock; all state changes on its rising edge.
- `reset` in 1: synchronous reset, active-high. Takes effect on the rising edge of `clk` while high.
- `sel` in 1: chip-select from the address decode.
- `wr_n` in 1: core read/write strobe; 0 = write, 1 = read.
- `a` in 2: register address (core address bits [1:0]).
- `din` in 8: write data from the core.
- `dout` out 8: read data to the core; combinational from `sel`, `wr_n` and `a`; 8'h00 when `sel`=0.
- `txd` out 1: serial transmit; idle high.
- `rxd` in 1: serial receive; asynchronous, idle high.
- `irq` out 1: interrupt request, active-high, level.

## Operation
- Register map:
  - a=0 read STATUS: {4'b0, FE, OE, TDRE, RDRF}, where RDRF is bit0.
  - a=0 write CONTROL: bit0 RIE (receive irq enable), bit1 TIE (transmit irq enable); other bits ignored.
  - a=1 read returns RXDATA; a=1 write loads TXHOLD.
  - a=2 and a=3: DIV[7:0] and DIV[15:8], read/write.
- Write access: `sel`=1 and `wr_n`=0, sampled on the clock edge.
- Read access: `sel`=1 and `wr_n`=1. The core holds each read address for exactly one cycle.
- Read side effect: on the edge ending a read of a=1, clear RDRF, OE and FE.
- `irq` = (RIE & RDRF) | (TIE & TDRE), registered.
- Frame format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1). Each bit lasts DIV clocks.
- DIV values 0 and 1 are treated as 2.
- TX path, states IDLE → START → DATA(×8) → STOP → IDLE:
  - A write to a=1 with TDRE=1 loads TXHOLD and clears TDRE.
  - A write to a=1 with TDRE=0 is ignored; TXHOLD is unchanged and no flag is set.
  - In IDLE with TDRE=0: move TXHOLD to the shifter, set TDRE, enter START.
  - At the end of STOP, if TDRE=0, go directly to START with the new byte. There is no idle gap between back-to-back frames.
- RX path, states IDLE → START → DATA(×8) → STOP → IDLE:
  - `rxd` passes through a 2-flop synchroniser.
  - IDLE: on a synchronised falling edge, load the counter with DIV/2 (floor) and enter START.
  - START, at counter expiry: if the line is still 0, enter DATA with a DIV reload. Otherwise it is a false start: return to IDLE with no flag.
  - DATA: sample the line at each DIV expiry and shift in LSB first.
  - STOP, at the sample: deliver the byte.
    - If RDRF=0: load RXDATA and set RDRF. Set FE if the stop bit sampled 0.
    - If RDRF=1: set OE; RXDATA and FE are unchanged and the new byte is dropped.
  - Return to IDLE at the stop-bit sample point. This tolerates a short stop bit.
- DIV written mid-frame takes effect at the next counter reload. Bits already in progress are not retimed.
- Reset values:
  - `txd`=1, `irq`=0, DIV=DIV_RESET.
  - TDRE=1, RDRF=0, OE=0, FE=0, RIE=0, TIE=0, RXDATA=8'h00.
  - Both FSMs in IDLE.
  - Reset mid-frame aborts the frame and drives `txd` high on the next edge.

## Timing
- TX write to the first start-bit cycle: a write at edge N sets the TX FSM to START at edge N+1. `txd` goes low from edge N+1.
- Each TX bit occupies exactly DIV clocks. A full frame is 10×DIV clocks.
- TDRE re-asserts at edge N+1 when the shifter was idle, so a second byte may be written immediately.
- RX: RDRF sets at the edge of the stop-bit sample. That edge is 2 (synchroniser) + DIV/2 + 9×DIV clocks after the start edge arrives at `rxd`, ±1 clock.
- `irq` lags its flag changes by 1 clock.
- Simultaneous events:
  - Receive completion and a DATA read on the same edge: the read clears first, then the new byte loads. Result: RDRF=1, OE=0, RXDATA = new byte.
  - A TXHOLD write and a shifter load on the same edge cannot coincide, because the write requires TDRE=1.

## Test plan
- Reset, then read a=0, a=2, a=3 → 8'h02, 8'hB2, 8'h01. `txd`=1 and `irq`=0 during and after reset.
- DIV=4, write 8'hA5 to a=1 → `txd` sequence, 4 clocks each: 0,1,0,1,0,0,1,0,1,1. TDRE=1 one clock after the write.
- DIV=4, back-to-back writes 8'h55 then 8'h0F (second written after TDRE returns) → 20 contiguous bit periods with no idle gap. A third write while TDRE=0 is discarded.
- DIV=8, drive frame 8'h3C on `rxd` → RDRF=1, read a=1 returns 8'h3C, then STATUS reads 8'h02.
- Drive a frame with stop bit 0 → FE=1. Drive a second frame without reading → OE=1 and RXDATA retains the first byte. A DATA read clears RDRF, OE and FE.
- RIE=1, TIE=0, a 1-clock low glitch on `rxd` → no RDRF and `irq` stays 0. A valid frame raises `irq` one clock after RDRF. Asserting `reset` mid-TX frame → `txd`=1 next edge, STATUS=8'h02.
